// File: rtl/cmp32_seq.sv
// Sequences a 2W-bit magnitude compare over an external W-bit comparator:
// high halves first, low halves only when the high halves tie.
module cmp32_seq #(
  parameter int unsigned W      = 16,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*W-1:0]   op_a,
  input  logic [2*W-1:0]   op_b,
  output logic [W-1:0]     cmp_a,
  output logic [W-1:0]     cmp_b,
  input  logic             cmp_gt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   a_lo_q, b_lo_q;
  logic           sgn_diff_q;
  logic [W-1:0]   cmp_a_q, cmp_b_q;
  logic           gt_q, lt_q, eq_q;

  logic           halves_eq;
  logic           gt_hi;

  // The comparator inputs are registered, so this is the equality of
  // whichever halves are currently presented.
  assign halves_eq = (cmp_a_q == cmp_b_q);
  // Differing sign bits invert the unsigned high-half verdict.
  assign gt_hi     = cmp_gt ^ (SIGNED && sgn_diff_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_lo_q     <= '0;
      b_lo_q     <= '0;
      sgn_diff_q <= 1'b0;
      cmp_a_q    <= '0;
      cmp_b_q    <= '0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_lo_q     <= op_a[W-1:0];
            b_lo_q     <= op_b[W-1:0];
            sgn_diff_q <= op_a[2*W-1] ^ op_b[2*W-1];
            cmp_a_q    <= op_a[2*W-1:W];
            cmp_b_q    <= op_b[2*W-1:W];
            state_q    <= HI;
          end else begin
            state_q    <= IDLE;
          end
        end
        HI: begin
          if (halves_eq) begin
            cmp_a_q <= a_lo_q;
            cmp_b_q <= b_lo_q;
            state_q <= LO;
          end else begin
            gt_q    <= gt_hi;
            lt_q    <= !gt_hi;
            eq_q    <= 1'b0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            state_q <= DONE;
          end
        end
        LO: begin
          gt_q    <= cmp_gt;
          eq_q    <= halves_eq;
          lt_q    <= !cmp_gt && !halves_eq;
          cmp_a_q <= '0;
          cmp_b_q <= '0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == HI)   || (state_q == LO);
  assign done  = (state_q == DONE);
  assign cmp_a = cmp_a_q;
  assign cmp_b = cmp_b_q;
  assign gt    = gt_q;
  assign lt    = lt_q;
  assign eq    = eq_q;

endmodule

// File: tb/tb_cmp32_seq.sv
// Drives an unsigned and a signed cmp32_seq with the same stimulus and checks
// both every cycle against a transaction-level model.
module tb_cmp32_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;

  logic [15:0] cmpa_u, cmpb_u, cmpa_s, cmpb_s;
  logic        cgt_u, cgt_s;
  logic        ready_u, busy_u, done_u, gt_u, lt_u, eq_u;
  logic        ready_s, busy_s, done_s, gt_s, lt_s, eq_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign cgt_u = (cmpa_u > cmpb_u);
  assign cgt_s = (cmpa_s > cmpb_s);

  cmp32_seq #(.W(16), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cmp_a(cmpa_u), .cmp_b(cmpb_u), .cmp_gt(cgt_u),
    .ready(ready_u), .busy(busy_u), .done(done_u),
    .gt(gt_u), .lt(lt_u), .eq(eq_u)
  );

  cmp32_seq #(.W(16), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cmp_a(cmpa_s), .cmp_b(cmpb_s), .cmp_gt(cgt_s),
    .ready(ready_s), .busy(busy_s), .done(done_s),
    .gt(gt_s), .lt(lt_s), .eq(eq_s)
  );

  // Model: an accepted op occupies 1 or 2 busy cycles, then one done cycle.
  int          m_left = 0;
  int          m_age  = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_done = 1'b0;
  logic [2:0]  m_fu = '0, m_fs = '0;
  logic        m_was_ready;

  function automatic logic [2:0] rel_u(input logic [31:0] a, input logic [31:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] rel_s(input logic [31:0] a, input logic [31:0] b);
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_age = 0; m_a = '0; m_b = '0;
      m_done = 1'b0; m_fu = '0; m_fs = '0;
    end else begin
      m_was_ready = (m_left == 0);
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        m_age++;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_fu   = rel_u(m_a, m_b);
          m_fs   = rel_s(m_a, m_b);
        end
      end
      if (m_was_ready && start) begin
        m_a    = op_a;
        m_b    = op_b;
        m_left = (op_a[31:16] == op_b[31:16]) ? 2 : 1;
        m_age  = 0;
      end
    end
  end

  function automatic logic [37:0] model_vec(input logic [2:0] flags);
    logic [15:0] ea, eb;
    ea = '0; eb = '0;
    if (m_left > 0 && m_age == 0) begin ea = m_a[31:16]; eb = m_b[31:16]; end
    if (m_left > 0 && m_age == 1) begin ea = m_a[15:0];  eb = m_b[15:0];  end
    return {m_left == 0, m_left > 0, m_done, ea, eb, flags};
  endfunction

  always @(negedge clk) begin
    logic [37:0] du, ds, eu, es;
    du = {ready_u, busy_u, done_u, cmpa_u, cmpb_u, gt_u, lt_u, eq_u};
    ds = {ready_s, busy_s, done_s, cmpa_s, cmpb_s, gt_s, lt_s, eq_s};
    eu = model_vec(m_fu);
    es = model_vec(m_fs);
    n_vec += 2;
    if (du !== eu) begin
      n_bad++;
      $display("FAIL cycle_uns t=%0t dut=%h model=%h", $time, du, eu);
    end
    if (ds !== es) begin
      n_bad++;
      $display("FAIL cycle_sgn t=%0t dut=%h model=%h", $time, ds, es);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Called at posedge+2 with the DUT ready; returns at posedge+2 of DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [2:0] fu, output logic [2:0] fs,
                        output logic [15:0] lo_a);
    logic [31:0] r;
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #2;
    start = 1'b0;
    r = $urandom; op_a = r;
    r = $urandom; op_b = r;
    lat = 0; lo_a = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (busy_u) lo_a = cmpa_u;
      if (done_u) begin lat = i + 1; break; end
    end
    fu = {gt_u, lt_u, eq_u};
    fs = {gt_s, lt_s, eq_s};
    #1;
  endtask

  initial begin
    int          lat;
    logic [2:0]  fu, fs;
    logic [15:0] lo_a;
    logic [31:0] r;

    #1;
    check("rst_flags", {26'd0, gt_u, lt_u, eq_u, gt_s, lt_s, eq_s}, 32'd0);
    check("rst_hs", {29'd0, ready_u, busy_u, done_u}, 32'h4);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_op(32'h0001_0000, 32'h0000_FFFF, lat, fu, fs, lo_a);
    check("t1_lat", lat, 2);
    check("t1_flags", {29'd0, fu}, 32'h4);

    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, fu, fs, lo_a);
    check("t2_lat", lat, 3);
    check("t2_flags_u", {29'd0, fu}, 32'h1);
    check("t2_flags_s", {29'd0, fs}, 32'h1);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, lat, fu, fs, lo_a);
    check("t3_lat", lat, 2);
    check("t3_flags_u", {29'd0, fu}, 32'h4);
    check("t3_flags_s", {29'd0, fs}, 32'h2);

    run_op(32'h1234_0001, 32'h1234_8000, lat, fu, fs, lo_a);
    check("t4_lat", lat, 3);
    check("t4_flags", {29'd0, fu}, 32'h2);
    check("t4_lo_cmpa", {16'd0, lo_a}, 32'h0001);

    run_op(32'hFFFF_8000, 32'hFFFF_0001, lat, fu, fs, lo_a);
    check("t4b_flags_s", {29'd0, fs}, 32'h4);

    // Start held high with operands alternating every cycle.
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op_a = (i % 2 == 0) ? 32'hAAAA_0001 : 32'h0000_0005;
      op_b = (i % 2 == 0) ? 32'hAAAA_0002 : 32'h7000_0005;
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Reset asserted while the low halves are being compared.
    start = 1'b1; op_a = 32'h5555_0003; op_b = 32'h5555_0002;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #1;
    check("t6_in_lo", {30'd0, busy_u, done_u}, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_flags", {26'd0, gt_u, lt_u, eq_u, gt_s, lt_s, eq_s}, 32'd0);
    check("t6_hs", {29'd0, ready_u, busy_u, done_u}, 32'h4);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) != 0);
      r = $urandom; op_a = r;
      case ($urandom_range(0, 3))
        0: op_b = op_a;
        1: begin r = $urandom; op_b = {op_a[31:16], r[15:0]}; end
        default: begin r = $urandom; op_b = r; end
      endcase
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
